// File: rtl/vga_rx_pkg.sv
// Shared types, default 640x480 timing and width helpers for the VGA link receiver.
package vga_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

    // Default 640x480@60 timing, identical to the transmitter side.
    localparam int DEF_IMG_W        = 640;
    localparam int DEF_IMG_H        = 480;
    localparam int DEF_H_TOTAL      = 800;
    localparam int DEF_V_TOTAL      = 525;
    localparam int DEF_H_SYNC_WIDTH = 96;
    localparam int DEF_H_BACK_PORCH = 48;
    localparam int DEF_V_SYNC_WIDTH = 2;
    localparam int DEF_V_BACK_PORCH = 33;
    localparam int DEF_PIX_SKEW     = 0;
    localparam int DEF_LOCK_FRAMES  = 2;

    // Counter/address width for a range of n values (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_sync_measure.sv
// Registers the sync/pixel inputs, detects sync falling edges and measures
// line and frame length with saturating counters.
module vga_sync_measure
    import vga_rx_pkg::*;
#(
    parameter int  H_TOTAL = DEF_H_TOTAL,
    parameter int  V_TOTAL = DEF_V_TOTAL,
    localparam int H_CW    = cnt_width(H_TOTAL),
    localparam int V_CW    = cnt_width(V_TOTAL)
) (
    input  logic            clk_in,
    input  logic            resetn,
    input  logic            hsync_in,
    input  logic            vsync_in,
    input  logic [3:0]      pix_in,
    input  logic            rearm,
    output logic [H_CW-1:0] h_cnt,
    output logic [V_CW-1:0] v_cnt,
    output logic [3:0]      pix,
    output logic            vs_fall,
    output logic            frame_tick,
    output logic            line_err,
    output logic            frame_err
);

    localparam logic [H_CW-1:0] H_LAST = H_CW'(H_TOTAL - 1);
    localparam logic [V_CW-1:0] V_LAST = V_CW'(V_TOTAL - 1);

    logic       hs_q, hs_qq, vs_q, vs_qq;
    logic [3:0] pix_q;
    logic       hs_fall;
    logic       vs_pend;
    logic       h_over, v_over;
    logic       h_armed, v_armed;

    assign hs_fall    = hs_qq & ~hs_q;
    assign vs_fall    = vs_qq & ~vs_q;
    assign frame_tick = hs_fall & (vs_fall | vs_pend);

    // A counter parked at its last value still flags a too-long line/frame via the over bit.
    assign line_err  = hs_fall & h_armed & (h_over | (h_cnt != H_LAST));
    assign frame_err = frame_tick & v_armed & (v_over | (v_cnt != V_LAST));

    // NOTE: sync history resets to the idle (high) level so reset release is not seen as an edge.
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            hs_q  <= 1'b1;
            hs_qq <= 1'b1;
            vs_q  <= 1'b1;
            vs_qq <= 1'b1;
            pix_q <= '0;
            pix   <= '0;
        end else begin
            // NOTE: non-blocking assignments let the second stage see the old first-stage value.
            hs_q  <= hsync_in;
            hs_qq <= hs_q;
            vs_q  <= vsync_in;
            vs_qq <= vs_q;
            pix_q <= pix_in;
            pix   <= pix_q;
        end
    end

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            h_cnt   <= '0;
            h_over  <= 1'b0;
            h_armed <= 1'b0;
        end else begin
            if (hs_fall) begin
                h_cnt  <= '0;
                h_over <= 1'b0;
            end else if (h_cnt == H_LAST) begin
                h_over <= 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
            if (rearm)        h_armed <= 1'b0;
            else if (hs_fall) h_armed <= 1'b1;
        end
    end

    // A Vsync edge between Hsync edges is held in vs_pend until the next line start.
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            v_cnt   <= '0;
            v_over  <= 1'b0;
            v_armed <= 1'b0;
            vs_pend <= 1'b0;
        end else begin
            if (frame_tick) begin
                v_cnt  <= '0;
                v_over <= 1'b0;
            end else if (hs_fall) begin
                if (v_cnt == V_LAST) v_over <= 1'b1;
                else                 v_cnt  <= v_cnt + 1'b1;
            end
            if (hs_fall)      vs_pend <= 1'b0;
            else if (vs_fall) vs_pend <= 1'b1;
            if (rearm)           v_armed <= 1'b0;
            else if (frame_tick) v_armed <= 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_rx.sv
// VGA link receiver: lock FSM over measured sync timing plus the framebuffer
// write path for active pixels once locked.
module vga_sync_rx
    import vga_rx_pkg::*;
#(
    parameter int  IMG_W        = DEF_IMG_W,
    parameter int  IMG_H        = DEF_IMG_H,
    parameter int  H_TOTAL      = DEF_H_TOTAL,
    parameter int  V_TOTAL      = DEF_V_TOTAL,
    parameter int  H_SYNC_WIDTH = DEF_H_SYNC_WIDTH,
    parameter int  H_BACK_PORCH = DEF_H_BACK_PORCH,
    parameter int  V_SYNC_WIDTH = DEF_V_SYNC_WIDTH,
    parameter int  V_BACK_PORCH = DEF_V_BACK_PORCH,
    parameter int  PIX_SKEW     = DEF_PIX_SKEW,
    parameter int  LOCK_FRAMES  = DEF_LOCK_FRAMES,
    localparam int ADDR_W       = cnt_width(IMG_W * IMG_H)
) (
    input  logic              clk_in,
    input  logic              resetn,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [3:0]        pix_in,
    output logic              locked,
    output logic              frame_start,
    output logic              timing_err,
    output logic              pix_we,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [3:0]        pix_data
);

    localparam int H_CW = cnt_width(H_TOTAL);
    localparam int V_CW = cnt_width(V_TOTAL);
    localparam int GF_W = cnt_width(LOCK_FRAMES + 1);
    localparam int X0   = H_SYNC_WIDTH + H_BACK_PORCH + PIX_SKEW;
    localparam int Y0   = V_SYNC_WIDTH + V_BACK_PORCH;

    rx_state_e        state;
    logic [GF_W-1:0]  good_frames;
    logic             dirty;
    logic [H_CW-1:0]  h_cnt;
    logic [V_CW-1:0]  v_cnt;
    logic [3:0]       meas_pix;
    logic             vs_fall, frame_tick, line_err, frame_err;
    logic             err_now, rearm;
    logic [31:0]      h_ext, v_ext, x_off, y_off;
    logic             in_win;
    logic [ADDR_W-1:0] wr_addr;

    assign err_now = line_err | frame_err;
    assign rearm   = (state == LOCKED) && err_now;

    vga_sync_measure #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_measure (
        .clk_in     (clk_in),
        .resetn     (resetn),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .pix_in     (pix_in),
        .rearm      (rearm),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .pix        (meas_pix),
        .vs_fall    (vs_fall),
        .frame_tick (frame_tick),
        .line_err   (line_err),
        .frame_err  (frame_err)
    );

    // dirty remembers a mid-frame line error so that frame cannot count as good.
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            state       <= SEARCH;
            good_frames <= '0;
            dirty       <= 1'b0;
            locked      <= 1'b0;
            timing_err  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            timing_err  <= err_now && (state != SEARCH);
            frame_start <= (state == LOCKED) && vs_fall && !err_now;
            case (state)
                SEARCH: begin
                    if (frame_tick) begin
                        state       <= ALIGN;
                        good_frames <= '0;
                        dirty       <= 1'b0;
                    end
                end
                ALIGN: begin
                    if (frame_tick) begin
                        dirty <= 1'b0;
                        if (err_now || dirty) begin
                            good_frames <= '0;
                        end else if (32'(good_frames) + 32'd1 >= 32'(LOCK_FRAMES)) begin
                            state       <= LOCKED;
                            locked      <= 1'b1;
                            good_frames <= '0;
                        end else begin
                            good_frames <= good_frames + 1'b1;
                        end
                    end else if (err_now) begin
                        good_frames <= '0;
                        dirty       <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (err_now) begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    assign h_ext   = 32'(h_cnt);
    assign v_ext   = 32'(v_cnt);
    assign x_off   = h_ext - 32'(X0);
    assign y_off   = v_ext - 32'(Y0);
    assign in_win  = (h_ext >= 32'(X0)) && (h_ext < 32'(X0 + IMG_W)) &&
                     (v_ext >= 32'(Y0)) && (v_ext < 32'(Y0 + IMG_H));
    assign wr_addr = ADDR_W'(y_off * 32'(IMG_W) + x_off);

    // Address and data only move with a write; they hold between writes.
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            pix_we   <= 1'b0;
            pix_addr <= '0;
            pix_data <= '0;
        end else begin
            pix_we <= (state == LOCKED) && in_win;
            if ((state == LOCKED) && in_win) begin
                pix_addr <= wr_addr;
                pix_data <= meas_pix;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx on a reduced 20x6 mode; a second instance runs
// with PIX_SKEW=2 on a pixel stream delayed by two clocks.
module tb_vga_sync_rx;

    localparam int IMG_W   = 20;
    localparam int IMG_H   = 6;
    localparam int H_TOTAL = 32;
    localparam int V_TOTAL = 12;
    localparam int HS      = 4;
    localparam int HBP     = 3;
    localparam int VS      = 2;
    localparam int VBP     = 2;
    localparam int NPIX    = IMG_W * IMG_H;
    localparam int AW      = 7;

    logic          clk_in = 1'b0;
    logic          resetn = 1'b0;
    logic          hsync_in = 1'b1;
    logic          vsync_in = 1'b1;
    logic [3:0]    pix_in = '0;
    logic [3:0]    pix_skew = '0;
    logic [3:0]    pd0 = '0, pd1 = '0;

    logic          locked, frame_start, timing_err, pix_we;
    logic [AW-1:0] pix_addr;
    logic [3:0]    pix_data;
    logic          locked2, frame_start2, timing_err2, pix_we2;
    logic [AW-1:0] pix_addr2;
    logic [3:0]    pix_data2;

    int vectors = 0;
    int miscompares = 0;

    int we_cnt, we_cnt2, first_addr, first_data, last_addr;
    int err_cnt, err_locked, fs_cnt;
    int cap[NPIX];
    int cap2[NPIX];

    always #5 clk_in = ~clk_in;

    vga_sync_rx #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
        .H_SYNC_WIDTH(HS), .H_BACK_PORCH(HBP), .V_SYNC_WIDTH(VS), .V_BACK_PORCH(VBP),
        .PIX_SKEW(0), .LOCK_FRAMES(2)
    ) dut (
        .clk_in(clk_in), .resetn(resetn), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pix_in(pix_in), .locked(locked), .frame_start(frame_start),
        .timing_err(timing_err), .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data)
    );

    vga_sync_rx #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
        .H_SYNC_WIDTH(HS), .H_BACK_PORCH(HBP), .V_SYNC_WIDTH(VS), .V_BACK_PORCH(VBP),
        .PIX_SKEW(2), .LOCK_FRAMES(2)
    ) dut_skew (
        .clk_in(clk_in), .resetn(resetn), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pix_in(pix_skew), .locked(locked2), .frame_start(frame_start2),
        .timing_err(timing_err2), .pix_we(pix_we2), .pix_addr(pix_addr2), .pix_data(pix_data2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_pix(input int x, input int y);
        return (x + y) & 15;
    endfunction

    function automatic int count_bad(input bit skewed);
        int n = 0;
        for (int a = 0; a < NPIX; a++) begin
            if ((skewed ? cap2[a] : cap[a]) != model_pix(a % IMG_W, a / IMG_W)) n++;
        end
        return n;
    endfunction

    task automatic clear_mon();
        we_cnt = 0; we_cnt2 = 0; first_addr = -1; first_data = -1; last_addr = -1;
        err_cnt = 0; err_locked = -1; fs_cnt = 0;
        for (int a = 0; a < NPIX; a++) begin
            cap[a]  = -1;
            cap2[a] = -1;
        end
    endtask

    // One pixel clock: sample outputs mid-cycle, then drive the next input values.
    task automatic tick(input logic hs, input logic vs, input logic [3:0] p);
        @(negedge clk_in);
        if (pix_we) begin
            if (we_cnt == 0) begin
                first_addr = int'(pix_addr);
                first_data = int'(pix_data);
            end
            last_addr = int'(pix_addr);
            if (int'(pix_addr) < NPIX) cap[pix_addr] = int'(pix_data);
            we_cnt++;
        end
        if (pix_we2) begin
            if (int'(pix_addr2) < NPIX) cap2[pix_addr2] = int'(pix_data2);
            we_cnt2++;
        end
        if (timing_err) begin
            err_cnt++;
            err_locked = int'(locked);
        end
        if (frame_start) fs_cnt++;
        hsync_in = hs;
        vsync_in = vs;
        pix_in   = p;
        pix_skew = pd1;
        pd1      = pd0;
        pd0      = p;
    endtask

    // Transmitter model; short_line is sent one clock short, stop_after (>=0) cuts the frame.
    task automatic send_frame(input int n_lines, input int short_line, input int stop_after);
        int sent, len, x, y;
        logic [3:0] p;
        sent = 0;
        for (int l = 0; l < n_lines; l++) begin
            len = (l == short_line) ? H_TOTAL - 1 : H_TOTAL;
            for (int h = 0; h < len; h++) begin
                x = h - HS - HBP;
                y = l - VS - VBP;
                p = '0;
                if (x >= 0 && x < IMG_W && y >= 0 && y < IMG_H) p = 4'(model_pix(x, y));
                if (stop_after >= 0 && sent == stop_after) return;
                tick((h < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1, p);
                sent++;
            end
        end
    endtask

    initial begin
        clear_mon();
        repeat (3) tick(1'b1, 1'b1, 4'h0);
        check("rst_locked", 32'(locked), 0);
        check("rst_frame_start", 32'(frame_start), 0);
        check("rst_timing_err", 32'(timing_err), 0);
        check("rst_pix_we", 32'(pix_we), 0);
        check("rst_pix_addr", 32'(pix_addr), 0);
        check("rst_pix_data", 32'(pix_data), 0);
        resetn = 1'b1;
        clear_mon();

        // Clean frames: lock lands on the Vsync edge that starts frame 3.
        send_frame(V_TOTAL, -1, -1);
        check("f1_locked", 32'(locked), 0);
        send_frame(V_TOTAL, -1, -1);
        check("f2_locked", 32'(locked), 0);
        send_frame(V_TOTAL, -1, -1);
        check("f3_locked", 32'(locked), 1);
        check("f3_timing_err_cnt", 32'(err_cnt), 0);
        check("f3_frame_start_cnt", 32'(fs_cnt), 0);
        check("f3_we_cnt", 32'(we_cnt), NPIX);
        check("f3_first_addr", 32'(first_addr), 0);
        check("f3_first_data", 32'(first_data), 0);
        check("f3_last_addr", 32'(last_addr), NPIX - 1);
        check("f3_content_bad", 32'(count_bad(1'b0)), 0);
        check("f3_skew_we_cnt", 32'(we_cnt2), NPIX);
        check("f3_skew_content_bad", 32'(count_bad(1'b1)), 0);

        clear_mon();
        send_frame(V_TOTAL, -1, -1);
        check("f4_frame_start_cnt", 32'(fs_cnt), 1);
        check("f4_we_cnt", 32'(we_cnt), NPIX);
        check("f4_content_bad", 32'(count_bad(1'b0)), 0);
        check("f4_skew_content_bad", 32'(count_bad(1'b1)), 0);

        // Line 6 is one clock short: error at line 7's Hsync, lock lost on that cycle.
        clear_mon();
        send_frame(V_TOTAL, 6, -1);
        check("f5_timing_err_cnt", 32'(err_cnt), 1);
        check("f5_locked_at_err", 32'(err_locked), 0);
        check("f5_locked", 32'(locked), 0);
        check("f5_we_cnt", 32'(we_cnt), 3 * IMG_W);

        // Realign; a 13-line frame while good_frames=1 pushes lock out to frame 10.
        clear_mon();
        send_frame(V_TOTAL, -1, -1);
        send_frame(V_TOTAL + 1, -1, -1);
        send_frame(V_TOTAL, -1, -1);
        send_frame(V_TOTAL, -1, -1);
        check("f9_timing_err_cnt", 32'(err_cnt), 1);
        check("f9_locked", 32'(locked), 0);
        send_frame(V_TOTAL, -1, -1);
        check("f10_locked", 32'(locked), 1);

        // Stop mid-line 6 after h=14; outputs then show the write for h=11 (x=4, y=2).
        send_frame(V_TOTAL, -1, 6 * H_TOTAL + 15);
        check("pre_rst_locked", 32'(locked), 1);
        check("pre_rst_pix_we", 32'(pix_we), 1);
        check("pre_rst_pix_addr", 32'(pix_addr), 2 * IMG_W + 4);
        check("pre_rst_pix_data", 32'(pix_data), 6);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_locked", 32'(locked), 0);
        check("async_rst_pix_we", 32'(pix_we), 0);
        check("async_rst_pix_addr", 32'(pix_addr), 0);
        check("async_rst_pix_data", 32'(pix_data), 0);
        check("async_rst_timing_err", 32'(timing_err), 0);
        check("async_rst_frame_start", 32'(frame_start), 0);
        repeat (4) tick(1'b1, 1'b1, 4'h0);
        resetn = 1'b1;

        clear_mon();
        send_frame(V_TOTAL, -1, -1);
        send_frame(V_TOTAL, -1, -1);
        check("relock_fb_locked", 32'(locked), 0);
        send_frame(V_TOTAL, -1, -1);
        check("relock_fc_locked", 32'(locked), 1);
        check("relock_we_cnt", 32'(we_cnt), NPIX);
        check("relock_content_bad", 32'(count_bad(1'b0)), 0);
        check("relock_timing_err_cnt", 32'(err_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
